// File: rtl/traffic_pkg.sv
// Shared light codes and the phase encoding for the two-approach traffic phase scheduler.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;

    localparam logic [1:0] STOP   = 2'b00;
    localparam logic [1:0] FLASH  = 2'b01;
    localparam logic [1:0] WALK   = 2'b10;

    // NIGHT only becomes reachable when TRAFFIC_NIGHT_FLASH_EN is defined.
    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        RED_BA = 3'd5,
        NIGHT  = 3'd6
    } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Cycles-in-state counter: cleared on state entry, saturating at MAX_GREEN, with terminal compares.
module phase_timer #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 20,
    parameter int YEL_T     = 3,
    parameter int RED_T     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic min_done,
    output logic max_done,
    output logic yel_done,
    output logic red_done
);

    localparam int TW = $clog2(MAX_GREEN + 1);
    localparam logic [TW-1:0] MAX_T  = TW'(MAX_GREEN);
    localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_M1 = TW'(YEL_T - 1);
    localparam logic [TW-1:0] RED_M1 = TW'(RED_T - 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (timer != MAX_T) begin
            timer <= timer + TW'(1);
        end
    end

    assign min_done = (timer >= MIN_M1);
    assign max_done = (timer == MAX_M1);
    assign yel_done = (timer == YEL_M1);
    assign red_done = (timer == RED_M1);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-approach phase scheduler: demand latches, green/yellow/all-red FSM and lamp decode.
// Optional night flashing mode is enabled with TRAFFIC_NIGHT_FLASH_EN (adds the night input).
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MAX_GREEN  = 20,
    parameter int YEL_T      = 3,
    parameter int RED_T      = 2
`ifdef TRAFFIC_NIGHT_FLASH_EN
    ,
    parameter int FLASH_HALF = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sa,
    input  logic       sb,
    input  logic       btn_a,
    input  logic       btn_b,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [1:0] a,
    output logic [1:0] b,
    output logic [1:0] pa,
    output logic [1:0] pb,
    output logic [2:0] phase
);

    phase_t state, state_next;
    logic   dem_a, dem_b;
    logic   go_a, go_b;
    logic   min_done, max_done, yel_done, red_done;
    logic   enter_a, enter_b;

    phase_timer #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YEL_T     (YEL_T),
        .RED_T     (RED_T)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_next != state),
        .min_done (min_done),
        .max_done (max_done),
        .yel_done (yel_done),
        .red_done (red_done)
    );

    // Night mode makes a green behave as if the other side were waiting.
`ifdef TRAFFIC_NIGHT_FLASH_EN
    assign go_a = dem_a | night;
    assign go_b = dem_b | night;
`else
    assign go_a = dem_a;
    assign go_b = dem_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RED_BA;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            A_GRN:  if (go_b && (min_done || max_done)) state_next = A_YEL;
            A_YEL:  if (yel_done) state_next = RED_AB;
            RED_AB: if (red_done) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
                        state_next = night ? NIGHT : B_GRN;
`else
                        state_next = B_GRN;
`endif
                    end
            B_GRN:  if (go_a && (min_done || max_done)) state_next = B_YEL;
            B_YEL:  if (yel_done) state_next = RED_BA;
            RED_BA: if (red_done) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
                        state_next = night ? NIGHT : A_GRN;
`else
                        state_next = A_GRN;
`endif
                    end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            NIGHT:  if (!night) state_next = RED_BA;
`endif
            default: state_next = RED_BA;
        endcase
    end

    // Clearing on entry to the own green wins over a set in the same cycle.
    assign enter_a = (state_next == A_GRN) && (state != A_GRN);
    assign enter_b = (state_next == B_GRN) && (state != B_GRN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dem_a <= 1'b0;
            dem_b <= 1'b0;
        end else begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
            if (enter_a || state == NIGHT) begin
`else
            if (enter_a) begin
`endif
                dem_a <= 1'b0;
            end else if ((state != A_GRN) && (state != A_YEL) && (sa || btn_b)) begin
                dem_a <= 1'b1;
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            if (enter_b || state == NIGHT) begin
`else
            if (enter_b) begin
`endif
                dem_b <= 1'b0;
            end else if ((state != B_GRN) && (state != B_YEL) && (sb || btn_a)) begin
                dem_b <= 1'b1;
            end
        end
    end

`ifdef TRAFFIC_NIGHT_FLASH_EN
    localparam int FW = $clog2(FLASH_HALF) + 1;
    localparam logic [FW-1:0] FLASH_M1 = FW'(FLASH_HALF - 1);

    logic [FW-1:0] flash_cnt;
    logic          flash_off;

    // Flash pattern restarts in its lit half on every entry to NIGHT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_cnt <= '0;
            flash_off <= 1'b0;
        end else if (state != NIGHT) begin
            flash_cnt <= '0;
            flash_off <= 1'b0;
        end else if (flash_cnt == FLASH_M1) begin
            flash_cnt <= '0;
            flash_off <= ~flash_off;
        end else begin
            flash_cnt <= flash_cnt + FW'(1);
        end
    end
`endif

    always_comb begin
        a     = RED;
        b     = RED;
        pa    = STOP;
        pb    = STOP;
        phase = state;
        case (state)
            A_GRN: begin a = GREEN;  pb = WALK;  end
            A_YEL: begin a = YELLOW; pb = FLASH; end
            B_GRN: begin b = GREEN;  pa = WALK;  end
            B_YEL: begin b = YELLOW; pa = FLASH; end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            NIGHT: begin
                a = flash_off ? OFF : YELLOW;
                b = flash_off ? OFF : RED;
            end
`endif
            default: ;
        endcase
    end

endmodule
